// File: rtl/cache.sv
// Direct-mapped write-through cache, 2-byte blocks, 8-bit data, single outstanding request.
// Optional snoop invalidate in IDLE enabled by defining CACHE_INVALIDATE_EN.
//
// state | meaning
// IDLE  | waiting for cpu_request_ready; read hits answered from the array
// MEM   | memory_request presented, waiting for memory_response_ready
// RESP  | data_out valid, waiting for cpu_request_ready to drop
module cache #(
   parameter int LINES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [24:0] cpu_request,
   input  logic        cpu_request_ready,
   input  logic [15:0] invalidate_address,
   input  logic [15:0] memory_response,
   input  logic        memory_response_ready,
   output logic [24:0] memory_request,
   output logic        memory_request_ready,
   output logic [7:0]  data_out,
   output logic        data_out_ready
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 15 - IDX_W;

   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

   state_t            state_q;
   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [15:0]       data_q [LINES];
   logic [24:0]       mem_req_q;
   logic              mem_req_rdy_q;
   logic              dout_rdy_q;
   logic [7:0]        dout_q;

   logic              req_wr;
   logic [15:0]       req_addr;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic              req_hit;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              fill_en;

   assign req_wr   = cpu_request[24];
   assign req_addr = cpu_request[15:0];
   assign req_idx  = req_addr[IDX_W:1];
   assign req_tag  = req_addr[15:IDX_W+1];
   assign req_hit  = !req_wr && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // The registered request doubles as the fill address for the returning block.
   assign fill_idx = mem_req_q[IDX_W:1];
   assign fill_tag = mem_req_q[15:IDX_W+1];
   assign fill_en  = (state_q == MEM) && memory_response_ready;

`ifdef CACHE_INVALIDATE_EN
   logic [IDX_W-1:0] inv_idx;
   logic [TAG_W-1:0] inv_tag;
   logic             inv_hit;
   logic             unused_inv;
   assign inv_idx    = invalidate_address[IDX_W:1];
   assign inv_tag    = invalidate_address[15:IDX_W+1];
   assign inv_hit    = valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
   assign unused_inv = invalidate_address[0];
`else
   logic unused_inv;
   assign unused_inv = ^invalidate_address;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         valid_q       <= '0;
         mem_req_q     <= '0;
         mem_req_rdy_q <= 1'b0;
         dout_rdy_q    <= 1'b0;
         dout_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
`ifdef CACHE_INVALIDATE_EN
               // Fills only happen in MEM, so an invalidate can never race a fill here.
               if (inv_hit) valid_q[inv_idx] <= 1'b0;
`endif
               if (cpu_request_ready) begin
                  if (req_hit) begin
                     dout_q     <= req_addr[0] ? data_q[req_idx][15:8] : data_q[req_idx][7:0];
                     dout_rdy_q <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     mem_req_q     <= {req_wr, (req_wr ? cpu_request[23:16] : 8'h00), req_addr};
                     mem_req_rdy_q <= 1'b1;
                     state_q       <= MEM;
                  end
               end
            end
            MEM: begin
               if (memory_response_ready) begin
                  valid_q[fill_idx] <= 1'b1;
                  mem_req_rdy_q     <= 1'b0;
                  dout_q            <= mem_req_q[0] ? memory_response[15:8] : memory_response[7:0];
                  dout_rdy_q        <= 1'b1;
                  state_q           <= RESP;
               end
            end
            RESP: begin
               if (!cpu_request_ready) begin
                  dout_rdy_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= memory_response;
      end
   end

   assign memory_request       = mem_req_q;
   assign memory_request_ready = mem_req_rdy_q;
   assign data_out             = dout_q;
   assign data_out_ready       = dout_rdy_q;

endmodule

// File: tb/tb_cache.sv
// Bench for cache: transaction-level model (byte memory + per-line valid/tag/block) predicts
// every output after each clock edge; one compare process checks them, directed cases pin literals.
module tb_cache;
   localparam int LINES = 64;
   localparam int IDX_W = $clog2(LINES);

   logic        clock = 1'b0;
   logic        reset;
   logic [24:0] cpu_request;
   logic        cpu_request_ready;
   logic [15:0] invalidate_address;
   logic [15:0] memory_response;
   logic        memory_response_ready;
   logic [24:0] memory_request;
   logic        memory_request_ready;
   logic [7:0]  data_out;
   logic        data_out_ready;

   cache #(.LINES(LINES)) dut (
      .clock                (clock),
      .reset                (reset),
      .cpu_request          (cpu_request),
      .cpu_request_ready    (cpu_request_ready),
      .invalidate_address   (invalidate_address),
      .memory_response      (memory_response),
      .memory_response_ready(memory_response_ready),
      .memory_request       (memory_request),
      .memory_request_ready (memory_request_ready),
      .data_out             (data_out),
      .data_out_ready       (data_out_ready)
   );

   always #5 clock = ~clock;

   logic [7:0]  mem    [65536];
   bit          mvalid [LINES];
   int          mtag   [LINES];
   logic [15:0] mdata  [LINES];

   bit          chk_en = 1'b0;
   bit          exp_mreq_rdy, exp_dout_rdy, exp_mreq_zero;
   logic [24:0] exp_mreq;
   logic [7:0]  exp_dout;
   int          n_cmp = 0;
   int          n_bad = 0;

   bit          miss;
   logic [24:0] req;
   logic [7:0]  dout;

   function automatic int line_of(input logic [15:0] a);
      return (int'(a) >> 1) % LINES;
   endfunction

   function automatic int tag_of(input logic [15:0] a);
      return int'(a) >> (IDX_W + 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model effect of an edge where the cache sits in IDLE.
   task automatic idle_edge();
`ifdef CACHE_INVALIDATE_EN
      int i;
      i = line_of(invalidate_address);
      if (mvalid[i] && mtag[i] == tag_of(invalidate_address)) mvalid[i] = 1'b0;
`endif
   endtask

   always @(posedge clock) begin
      #1;
      if (chk_en) begin
         chk("mreq_rdy", 32'(memory_request_ready), 32'(exp_mreq_rdy));
         chk("dout_rdy", 32'(data_out_ready), 32'(exp_dout_rdy));
         chk("data_out", 32'(data_out), 32'(exp_dout));
         if (exp_mreq_rdy || exp_mreq_zero)
            chk("mreq", 32'(memory_request), 32'(exp_mreq));
      end
   end

   // One full transaction starting at a negedge with the cache in IDLE; ends back in IDLE.
   task automatic access(input bit w, input logic [15:0] a, input logic [7:0] wd,
                         output bit miss_o, output logic [24:0] req_o, output logic [7:0] dout_o);
      int          i;
      bit          hit;
      logic [15:0] blk;
      i   = line_of(a);
      hit = !w && mvalid[i] && (mtag[i] == tag_of(a));
      cpu_request           = {w, wd, a};
      cpu_request_ready     = 1'b1;
      memory_response       = 16'($urandom);
      memory_response_ready = 1'($urandom_range(0, 1));
      invalidate_address    = ($urandom_range(0, 3) == 0) ? (a ^ 16'h0001) : 16'($urandom);
      if (hit) begin
         exp_dout     = a[0] ? mdata[i][15:8] : mdata[i][7:0];
         exp_dout_rdy = 1'b1;
      end else begin
         exp_mreq     = {w, (w ? wd : 8'h00), a};
         exp_mreq_rdy = 1'b1;
      end
      idle_edge();
      @(negedge clock);
      miss_o = memory_request_ready;
      req_o  = memory_request;
      if (!hit) begin
         if (w) mem[a] = wd;
         repeat ($urandom_range(0, 3)) begin
            cpu_request           = 25'($urandom);
            memory_response       = 16'($urandom);
            memory_response_ready = 1'b0;
            @(negedge clock);
         end
         blk = {mem[a | 16'h0001], mem[a & 16'hFFFE]};
         memory_response       = blk;
         memory_response_ready = 1'b1;
         mvalid[i] = 1'b1;
         mtag[i]   = tag_of(a);
         mdata[i]  = blk;
         exp_dout     = a[0] ? blk[15:8] : blk[7:0];
         exp_dout_rdy = 1'b1;
         exp_mreq_rdy = 1'b0;
         @(negedge clock);
      end
      dout_o = data_out;
      repeat ($urandom_range(0, 2)) begin
         cpu_request           = 25'($urandom);
         memory_response       = 16'($urandom);
         memory_response_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      cpu_request_ready     = 1'b0;
      memory_response_ready = 1'b0;
      exp_dout_rdy          = 1'b0;
      @(negedge clock);
      repeat ($urandom_range(0, 2)) begin
         invalidate_address    = 16'($urandom);
         memory_response_ready = 1'($urandom_range(0, 1));
         idle_edge();
         @(negedge clock);
      end
      memory_response_ready = 1'b0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset                 = 1'b1;
      cpu_request           = '0;
      cpu_request_ready     = 1'b0;
      invalidate_address    = '0;
      memory_response       = '0;
      memory_response_ready = 1'b0;
      exp_mreq_rdy  = 1'b0;
      exp_dout_rdy  = 1'b0;
      exp_mreq_zero = 1'b1;
      exp_mreq      = '0;
      exp_dout      = '0;
      chk_en        = 1'b1;
      for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
      for (int k = 0; k < LINES; k++) begin
         mvalid[k] = 1'b0;
         mtag[k]   = 0;
         mdata[k]  = '0;
      end
      repeat (2) @(negedge clock);
      reset         = 1'b0;
      exp_mreq_zero = 1'b0;
      idle_edge();
      @(negedge clock);

      mem[16'h000C] = 8'h00;
      mem[16'h000D] = 8'h00;
      access(1'b0, 16'h000C, 8'hA5, miss, req, dout);
      chk("r029_miss", 32'(miss), 32'd1);
      chk("r029_req",  32'(req),  32'h0000_000C);
      chk("r029_dout", 32'(dout), 32'h00);

      access(1'b1, 16'h000C, 8'd55, miss, req, dout);
      chk("r030_w55_miss", 32'(miss), 32'd1);
      chk("r030_w55_req",  32'(req),  32'h0137_000C);
      chk("r030_w55_dout", 32'(dout), 32'd55);
      access(1'b1, 16'h000D, 8'd56, miss, req, dout);
      chk("r030_w56_miss", 32'(miss), 32'd1);
      chk("r030_w56_dout", 32'(dout), 32'd56);
      access(1'b0, 16'h000D, 8'h00, miss, req, dout);
      chk("r031_hit",  32'(miss), 32'd0);
      chk("r031_dout", 32'(dout), 32'd56);

      access(1'b0, 16'h000C, 8'h00, miss, req, dout);
      chk("r032_fill_hit",  32'(miss), 32'd0);
      chk("r032_fill_dout", 32'(dout), 32'd55);
      access(1'b0, 16'(16'h000C + 2 * LINES), 8'h00, miss, req, dout);
      chk("r032_conflict_miss", 32'(miss), 32'd1);
      access(1'b0, 16'h000C, 8'h00, miss, req, dout);
      chk("r032_reread_miss", 32'(miss), 32'd1);
      chk("r032_reread_dout", 32'(dout), 32'd55);

      access(1'b1, 16'hFFFE, 8'd33, miss, req, dout);
      access(1'b1, 16'hFFFF, 8'd34, miss, req, dout);
      access(1'b0, 16'hFFFE, 8'h00, miss, req, dout);
      chk("r033_fffe_hit",  32'(miss), 32'd0);
      chk("r033_fffe_dout", 32'(dout), 32'd33);
      access(1'b0, 16'hFFFF, 8'h00, miss, req, dout);
      chk("r033_ffff_hit",  32'(miss), 32'd0);
      chk("r033_ffff_dout", 32'(dout), 32'd34);

      // Reset while in MEM, coincident with a memory response.
      cpu_request       = {1'b1, 8'd77, 16'hFFFE};
      cpu_request_ready = 1'b1;
      exp_mreq          = {1'b1, 8'd77, 16'hFFFE};
      exp_mreq_rdy      = 1'b1;
      idle_edge();
      @(negedge clock);
      reset                 = 1'b1;
      memory_response       = 16'hBEEF;
      memory_response_ready = 1'b1;
      cpu_request_ready     = 1'b0;
      exp_mreq_rdy  = 1'b0;
      exp_dout_rdy  = 1'b0;
      exp_dout      = '0;
      exp_mreq      = '0;
      exp_mreq_zero = 1'b1;
      for (int k = 0; k < LINES; k++) mvalid[k] = 1'b0;
      @(negedge clock);
      chk("r033_rst_mreq_rdy", 32'(memory_request_ready), 32'd0);
      chk("r033_rst_dout",     32'(data_out), 32'd0);
      reset                 = 1'b0;
      memory_response_ready = 1'b0;
      exp_mreq_zero         = 1'b0;
      idle_edge();
      @(negedge clock);
      access(1'b0, 16'hFFFE, 8'h00, miss, req, dout);
      chk("r033_post_rst_miss", 32'(miss), 32'd1);
      chk("r033_post_rst_dout", 32'(dout), 32'd33);

      for (int a = 0; a < 1024; a++)
         access(1'b0, 16'(a), 8'($urandom), miss, req, dout);
      access(1'b0, 16'hFFFF, 8'h00, miss, req, dout);

      for (int n = 0; n < 1500; n++) begin
         logic [15:0] ra;
         ra = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 8 * LINES - 1)) : 16'($urandom);
         access(($urandom_range(0, 3) == 0), ra, 8'($urandom), miss, req, dout);
      end

      repeat (2) @(negedge clock);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
